// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Holds the FSM state encoding and the iteration-counter width function.
package div_pkg;

    localparam int N_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold N-1; clog2(N) is enough for every N >= 2.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W = cnt_w(N_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift, trial subtract, restore.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module div_step
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] i_rem,
    input  logic [N-1:0] i_quo,
    input  logic [N-1:0] i_dvs,
    output logic [N-1:0] o_rem,
    output logic [N-1:0] o_quo
);

    logic [N:0] w_shift;
    logic [N:0] w_trial;

    assign w_shift = {i_rem, i_quo[N-1]};
    assign w_trial = w_shift - {1'b0, i_dvs};

    // With i_rem < i_dvs the shifted value stays below 2*i_dvs, so the MSB of
    // the trial difference is a true sign bit and a restore always fits in N bits.
    assign o_rem = w_trial[N] ? w_shift[N-1:0] : w_trial[N-1:0];
    assign o_quo = {i_quo[N-2:0], ~w_trial[N]};

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Latency: done N+1 cycles after an accepted start (1 cycle on divide-by-zero or overflow).
// Backpressure: start is ignored while busy; a start in the done cycle is taken back-to-back.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (N == N_DEF) ? CNT_W : cnt_w(N);

    state_t         r_state;
    state_t         w_state_nxt;

    logic [N-1:0]   r_rem;
    logic [N-1:0]   r_quo;
    logic [N-1:0]   r_dvs;
    logic [CW-1:0]  r_cnt;
    logic           r_dbz;
    logic           r_ovf;

    logic [N-1:0]   w_rem_step;
    logic [N-1:0]   w_quo_step;
    logic           w_accept;
    logic           w_zero;
    logic           w_ovf;
    logic           w_err;

    assign w_accept = start && (r_state != RUN);
    assign w_zero   = (divisor == '0);
    assign w_ovf    = (dividend[2*N-1:N] >= divisor);
    assign w_err    = w_zero || w_ovf;
    assign busy     = (r_state == RUN);

    div_step #(
        .N      (N)
    ) u_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_step),
        .o_quo  (w_quo_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_err ? DONE : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Error jobs preload the saturated result so DONE publishes it like any other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_dvs <= divisor;
            r_dbz <= w_zero;
            r_ovf <= !w_zero && w_ovf;
            r_cnt <= CW'(N - 1);
            if (w_err) begin
                r_rem <= '0;
                r_quo <= '1;
            end else begin
                r_rem <= dividend[2*N-1:N];
                r_quo <= dividend[N-1:0];
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_step;
            r_quo <= w_quo_step;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Results are sampled on the edge that leaves DONE, before a back-to-back
    // start in the same cycle overwrites the working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= (r_state == DONE);
            if (r_state == DONE) begin
                quotient    <= r_quo;
                remainder   <= r_rem;
                div_by_zero <= r_dbz;
                overflow    <= r_ovf;
            end
        end
    end

endmodule
